// File: rtl/trng_word_collector.sv
// trng_word_collector: Von Neumann-debiased entropy packer into valid/ack words; `TRNG_RCT_EN adds a repetition-count health test.
module trng_word_collector #(
  parameter int WORD_WD    = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_LIMIT  = 31
) (
  input  logic               wb_clk_i,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               raw_bit_i,
  output logic [WORD_WD-1:0] trng_o,
  output logic               trng_valid_o,
  input  logic               trng_ack_i,
  output logic               health_fail_o
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(WORD_WD + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, FULL, FAIL} state_t;
  state_t state, state_nxt;
  logic sync_q, raw_s, phase, first;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [WORD_WD-1:0] shift;
  logic run, strobe, vn_en, done, load, rct_fail;
  if (SAMPLE_DIV < 2 || RCT_LIMIT < 2 || RCT_LIMIT > 255) begin : g_param_check
    $error("trng_word_collector: SAMPLE_DIV must be >= 2 and RCT_LIMIT within 2..255");
  end
  assign run    = en_i && (state == COLLECT || state == FULL);
  assign strobe = run && div == DW'(SAMPLE_DIV - 1);
  assign vn_en  = strobe && phase && state == COLLECT && first != raw_s;
  assign done   = state == COLLECT && cnt == CW'(WORD_WD);
  // A word leaves the shift register when the output slot is free or being consumed this cycle
  assign load   = en_i && !rct_fail &&
                  ((done && (!trng_valid_o || trng_ack_i)) || (state == FULL && trng_ack_i));
  always_comb begin
    state_nxt = !en_i ? IDLE :
                state == IDLE ? COLLECT :
                rct_fail ? FAIL :
                (done && trng_valid_o && !trng_ack_i) ? FULL :
                (state == FULL && trng_ack_i) ? COLLECT : state;
  end
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 1'b0;
      raw_s        <= 1'b0;
      div          <= '0;
      phase        <= 1'b0;
      first        <= 1'b0;
      shift        <= '0;
      cnt          <= '0;
      trng_o       <= '0;
      trng_valid_o <= 1'b0;
    end else begin
      sync_q <= raw_bit_i;
      raw_s  <= sync_q;
      if (!run) begin
        div   <= '0;
        phase <= 1'b0;
        first <= 1'b0;
        shift <= '0;
        cnt   <= '0;
      end else begin
        div <= strobe ? '0 : div + DW'(1);
        if (strobe) phase <= !phase;
        if (strobe && !phase) first <= raw_s;
        if (vn_en) shift <= {shift[WORD_WD-2:0], first};
        else if (load) shift <= '0;
        cnt <= vn_en ? cnt + CW'(1) : load ? '0 : cnt;
      end
      if (load) trng_o <= shift;
      trng_valid_o <= (!en_i || state == IDLE || state == FAIL || rct_fail) ? 1'b0 :
                      load ? 1'b1 : trng_ack_i ? 1'b0 : trng_valid_o;
    end
  end
`ifdef TRNG_RCT_EN
  logic [7:0] rct_cnt, rct_nxt;
  logic prev;
  // A zero count marks the first strobe of a session, which has no predecessor to compare
  always_comb begin
    rct_nxt = (rct_cnt == 8'd0 || prev != raw_s) ? 8'd1 :
              rct_cnt == 8'hff ? rct_cnt : rct_cnt + 8'd1;
  end
  assign rct_fail      = strobe && rct_nxt >= 8'(RCT_LIMIT);
  assign health_fail_o = state == FAIL;
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt <= 8'd0;
      prev    <= 1'b0;
    end else if (!run) begin
      rct_cnt <= 8'd0;
      prev    <= 1'b0;
    end else if (strobe) begin
      rct_cnt <= rct_nxt;
      prev    <= raw_s;
    end
  end
`else
  assign rct_fail      = 1'b0;
  assign health_fail_o = 1'b0;
`endif
endmodule

// File: tb/tb_trng_word_collector.sv
// tb_trng_word_collector: directed checks of debiasing, packing, handshake, health test and reset.
module tb_trng_word_collector;
  logic wb_clk_i = 1'b0, rst_n = 1'b0, en_i = 1'b0, raw_bit_i = 1'b0, trng_ack_i = 1'b0;
  logic [31:0] trng_o;
  logic trng_valid_o, health_fail_o;
  int checks = 0, fails = 0, mode = 0, e = 0;
`ifdef TRNG_RCT_EN
  localparam logic RCT_ON = 1'b1;
`else
  localparam logic RCT_ON = 1'b0;
`endif
  trng_word_collector dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .en_i(en_i), .raw_bit_i(raw_bit_i),
    .trng_o(trng_o), .trng_valid_o(trng_valid_o), .trng_ack_i(trng_ack_i),
    .health_fail_o(health_fail_o)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  // mode 0: pairs 10; 1: pairs 01,10; 2: 64-sample words alternating all-10 / all-01; 3: stuck 1
  function automatic bit sample_val(input int m, input int s);
    case (m)
      0: return s % 2 == 0;
      1: return s % 4 == 1 || s % 4 == 2;
      2: return (s % 2 == 0) ^ ((s / 64) % 2 == 1);
      default: return 1'b1;
    endcase
  endfunction
  // Sample k of a session is applied after enable edge 4k-4, so the strobe on edge 4k sees it
  initial forever begin
    @(posedge wb_clk_i);
    if (!en_i || !rst_n) e = 0;
    else begin
      e++;
      #1 raw_bit_i = sample_val(mode, (e - 1) / 4);
    end
  end
  task automatic skip(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask
  task automatic start_en;
    @(negedge wb_clk_i);
    en_i = 1'b1;
  endtask
  task automatic stop_en;
    @(negedge wb_clk_i);
    en_i = 1'b0;
    @(negedge wb_clk_i);
  endtask
  task automatic pulse_ack;
    trng_ack_i = 1'b1;
    @(negedge wb_clk_i);
    trng_ack_i = 1'b0;
  endtask
  task automatic wait_valid(input int max, output int n);
    int k = 0;
    n = -1;
    while (n < 0 && k < max) begin
      k++;
      @(negedge wb_clk_i);
      if (trng_valid_o === 1'b1) n = k;
    end
  endtask
  task automatic test_reset;
    skip(2);
    checks++; if (trng_o !== 32'h0) begin fails++; $display("FAIL reset_trng got %h want 00000000", trng_o); end
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", trng_valid_o); end
    checks++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL reset_health got %b want 0", health_fail_o); end
    @(negedge wb_clk_i);
    rst_n = 1'b1;
  endtask
  task automatic test_basic_word;
    int n;
    mode = 0;
    start_en;
    wait_valid(400, n);
    checks++; if (n < 250 || n > 266) begin fails++; $display("FAIL basic_latency got %0d want 250..266", n); end
    checks++; if (trng_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL basic_word got %h want ffffffff", trng_o); end
    pulse_ack;
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL basic_ack got %b want 0", trng_valid_o); end
    wait_valid(300, n);
    checks++; if (n + 1 != 256) begin fails++; $display("FAIL basic_interval got %0d want 256", n + 1); end
    checks++; if (trng_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL basic_word2 got %h want ffffffff", trng_o); end
  endtask
  task automatic test_mixed;
    int n;
    stop_en;
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL disable_valid got %b want 0", trng_valid_o); end
    checks++; if (trng_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL disable_retain got %h want ffffffff", trng_o); end
    mode = 1;
    start_en;
    wait_valid(400, n);
    checks++; if (n < 0) begin fails++; $display("FAIL mixed_timeout got %0d want >0", n); end
    checks++; if (trng_o !== 32'h5555_5555) begin fails++; $display("FAIL mixed_word got %h want 55555555", trng_o); end
    pulse_ack;
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL mixed_ack got %b want 0", trng_valid_o); end
    stop_en;
  endtask
  task automatic test_simultaneous;
    int n;
    bit drop = 1'b0;
    mode = 2;
    start_en;
    wait_valid(400, n);
    checks++; if (n < 0) begin fails++; $display("FAIL simul_timeout got %0d want >0", n); end
    repeat (255) begin
      @(negedge wb_clk_i);
      if (trng_valid_o !== 1'b1) drop = 1'b1;
    end
    pulse_ack;
    repeat (20) begin
      if (trng_valid_o !== 1'b1) drop = 1'b1;
      @(negedge wb_clk_i);
    end
    checks++; if (drop !== 1'b0) begin fails++; $display("FAIL simul_valid_drop got %b want 0", drop); end
    checks++; if (trng_o !== 32'h0) begin fails++; $display("FAIL simul_word got %h want 00000000", trng_o); end
    stop_en;
  endtask
  task automatic test_back_to_back;
    int n;
    mode = 2;
    start_en;
    wait_valid(400, n);
    checks++; if (n < 0) begin fails++; $display("FAIL b2b_timeout got %0d want >0", n); end
    skip(262);
    checks++; if (trng_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_full_valid got %b want 1", trng_valid_o); end
    checks++; if (trng_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL b2b_hold got %h want ffffffff", trng_o); end
    skip(4);
    pulse_ack;
    checks++; if (trng_valid_o !== 1'b1) begin fails++; $display("FAIL b2b_ack_valid got %b want 1", trng_valid_o); end
    checks++; if (trng_o !== 32'h0) begin fails++; $display("FAIL b2b_word2 got %h want 00000000", trng_o); end
    skip(10);
    pulse_ack;
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_ack2 got %b want 0", trng_valid_o); end
    wait_valid(400, n);
    checks++; if (n < 0) begin fails++; $display("FAIL b2b_word3_timeout got %0d want >0", n); end
    checks++; if (trng_o !== 32'hFFFF_FFFE) begin fails++; $display("FAIL b2b_word3 got %h want fffffffe", trng_o); end
    stop_en;
  endtask
  task automatic test_stuck;
    mode = 3;
    start_en;
    skip(122);
    checks++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL stuck_early got %b want 0", health_fail_o); end
    skip(6);
    checks++; if (health_fail_o !== RCT_ON) begin fails++; $display("FAIL stuck_health got %b want %b", health_fail_o, RCT_ON); end
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL stuck_valid got %b want 0", trng_valid_o); end
    stop_en;
    checks++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL stuck_clear got %b want 0", health_fail_o); end
    start_en;
    skip(10);
    checks++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL stuck_reenable got %b want 0", health_fail_o); end
    stop_en;
  endtask
  task automatic test_reset_mid_word;
    int n;
    mode = 0;
    start_en;
    skip(140);
    rst_n = 1'b0;
    #1;
    checks++; if (trng_o !== 32'h0) begin fails++; $display("FAIL midrst_trng got %h want 00000000", trng_o); end
    checks++; if (trng_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", trng_valid_o); end
    checks++; if (health_fail_o !== 1'b0) begin fails++; $display("FAIL midrst_health got %b want 0", health_fail_o); end
    @(negedge wb_clk_i);
    rst_n = 1'b1;
    wait_valid(400, n);
    checks++; if (n < 250 || n > 266) begin fails++; $display("FAIL midrst_latency got %0d want 250..266", n); end
    checks++; if (trng_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL midrst_word got %h want ffffffff", trng_o); end
  endtask
  initial begin
    test_reset;
    test_basic_word;
    test_mixed;
    test_simultaneous;
    test_back_to_back;
    test_stuck;
    test_reset_mid_word;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
